register_dump_controller: RTL and testbench

REGISTER_DUMP_CONTROLLER -- requirements
Module: register_dump_controller

---
 rtl/register_dump_controller_pkg.sv | 22 ++
 rtl/register_dump_controller_serializer.sv | 46 ++++
 rtl/register_dump_controller.sv | 158 +++++++++++++++
 tb/tb_register_dump_controller.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/register_dump_controller_pkg.sv
// Shared CPU debug package: dump FSM encoding, default register count and
// word geometry used by the register dump controller and its serializer.
package register_dump_controller_pkg;

  localparam int DUMP_NUM_REGS  = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEND   = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } dump_state_t;

  // Most significant byte of a word; bytes leave MSB first.
  function automatic logic [7:0] msb_byte(input logic [31:0] word);
    return word[31:24];
  endfunction

endpackage

// File: rtl/register_dump_controller_serializer.sv
// Word serializer: holds the captured register word, shifts it left one
// byte per transmitted byte and counts the byte position within the word.
module dump_word_serializer
  import register_dump_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  load,
  input  logic                  shift,
  input  logic [31:0]           load_data,
  output logic [7:0]            msb,
  output logic [BYTE_IDX_W-1:0] byte_idx,
  output logic                  last_byte
);

  logic [31:0] word;

  // Word capture/shift and byte counter; the counter is only advanced
  // below the last byte, so it never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= 32'h0000_0000;
      byte_idx <= '0;
    end else begin
      if (load) begin
        word <= load_data;
      end else if (shift) begin
        word <= {word[23:0], 8'h00};
      end else begin
        word <= word;
      end
      if (clr) begin
        byte_idx <= '0;
      end else if (shift && !last_byte) begin
        byte_idx <= byte_idx + {{(BYTE_IDX_W-1){1'b0}}, 1'b1};
      end else begin
        byte_idx <= byte_idx;
      end
    end
  end

  assign msb       = msb_byte(word);
  assign last_byte = (byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/register_dump_controller.sv
// Register dump controller: walks the register file from index 0 upwards
// and streams every word MSB first to a UART, one byte per tx_done.
// All outputs are registered; nothing combinational from start/abort/tx_done.
module register_dump_controller
  import register_dump_controller_pkg::*;
#(
  parameter int NUM_REGS = DUMP_NUM_REGS,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [31:0]       rf_read_data,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_done,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  dump_state_t           state;
  dump_state_t           next_state;
  logic [ADDR_W-1:0]     reg_idx;
  logic                  reg_clr;
  logic                  reg_inc;
  logic                  ser_clr;
  logic                  ser_load;
  logic                  ser_shift;
  logic [7:0]            ser_msb;
  logic [BYTE_IDX_W-1:0] ser_byte_idx;
  logic                  ser_last;
  logic                  ack;

  dump_word_serializer u_serializer (
    .clk       (clk),
    .reset     (reset),
    .clr       (ser_clr),
    .load      (ser_load),
    .shift     (ser_shift),
    .load_data (rf_read_data),
    .msb       (ser_msb),
    .byte_idx  (ser_byte_idx),
    .last_byte (ser_last)
  );

  // A tx_done coinciding with our own tx_start pulse belongs to an older
  // byte and must not acknowledge the one just offered.
  assign ack = tx_done && !tx_start;

  // Next-state and serializer/index control; abort wins over everything.
  always_comb begin
    next_state = state;
    reg_clr    = 1'b0;
    reg_inc    = 1'b0;
    ser_clr    = 1'b0;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = LOAD;
          reg_clr    = 1'b1;
          ser_clr    = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          ser_load   = 1'b1;
          next_state = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (abort) begin
          next_state = IDLE;
        end else if (ack) begin
          if (!ser_last) begin
            ser_shift  = 1'b1;
            next_state = SEND;
          end else if (reg_idx != LAST_IDX) begin
            reg_inc    = 1'b1;
            ser_clr    = 1'b1;
            next_state = LOAD;
          end else begin
            next_state = FINISH;
          end
        end else begin
          next_state = WAIT;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Register index: cleared at dump start, stepped after each word's last byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_idx <= '0;
    end else if (reg_clr) begin
      reg_idx <= '0;
    end else if (reg_inc) begin
      reg_idx <= reg_idx + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      reg_idx <= reg_idx;
    end
  end

  assign rf_read_addr = reg_idx;

  // Registered outputs: byte offer leaving SEND, busy from next state,
  // done leaving FINISH unless aborted there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= (state == SEND) && !abort;
      if (state == SEND) begin
        tx_data <= ser_msb;
      end else begin
        tx_data <= tx_data;
      end
      busy <= (next_state != IDLE);
      done <= (state == FINISH) && !abort;
    end
  end

endmodule

// File: tb/tb_register_dump_controller.sv
// Directed bench for register_dump_controller: register-file model, UART
// responder acknowledging each byte 3 cycles after tx_start, byte capture.
module tb_register_dump_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_done;
  logic        tx_done_resp;
  logic        tx_done_spur;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  logic [7:0]  cap [$];
  int          done_cnt;
  int          n_tests;
  int          n_fail;
  int          resp_cnt;

  register_dump_controller #(.NUM_REGS(32), .ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .rf_read_addr (rf_read_addr),
    .rf_read_data (rf_read_data),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_done      (tx_done),
    .busy         (busy),
    .done         (done)
  );

  assign rf_read_data = rf[rf_read_addr];
  assign tx_done      = tx_done_resp | tx_done_spur;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture offered bytes and done pulses at the falling edge.
  initial begin
    done_cnt = 0;
    forever begin
      @(negedge clk);
      if (tx_start) cap.push_back(tx_data);
      if (done) done_cnt++;
    end
  end

  // UART model: tx_done pulse in the third cycle after each tx_start.
  initial begin
    tx_done_resp = 1'b0;
    resp_cnt     = 0;
    forever begin
      @(negedge clk);
      tx_done_resp = 1'b0;
      if (reset) begin
        resp_cnt = 0;
      end else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) tx_done_resp = 1'b1;
        end
        if (tx_start) resp_cnt = 3;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [7:0] get_byte(input int i);
    if (i < cap.size()) return cap[i];
    return 8'hxx;
  endfunction

  function automatic logic [31:0] get_word(input int i);
    return {get_byte(i), get_byte(i + 1), get_byte(i + 2), get_byte(i + 3)};
  endfunction

  task automatic wait_bytes(input string tag, input int n);
    int budget;
    budget = 3000;
    while (cap.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, cap.size() >= n, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int n);
    int budget;
    budget = 3000;
    while (done_cnt < n && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, done_cnt, n);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_done"},     done,     1'b0);
    check({tag, "_busy"},     busy,     1'b0);
    check({tag, "_tx_data"},  tx_data,  8'h00);
    check({tag, "_rf_addr"},  rf_read_addr, 5'd0);
  endtask

  initial begin
    int errs;
    int done0;
    logic [31:0] w;
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    tx_done_spur = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0101_0101 * i;
    rf[0]  = 32'h0000_0000;
    rf[1]  = 32'h1122_3344;
    rf[31] = 32'hDEAD_BEEF;

    tick();
    tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    tick();

    // Full dump: start held 10 cycles, re-pulsed mid-dump, R2 written during R1.
    start = 1'b1;
    tick();
    check("lat_busy_n", busy, 1'b1);
    check("lat_txs_n", tx_start, 1'b0);
    tick();
    check("lat_txs_n1", tx_start, 1'b0);
    tick();
    check("lat_txs_n2", tx_start, 1'b1);
    check("lat_data_n2", tx_data, 8'h00);
    for (int i = 0; i < 7; i++) tick();
    start = 1'b0;
    wait_bytes("wait_r1", 5);
    rf[2] = 32'hCAFE_F00D;
    wait_bytes("wait_mid", 20);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("full_done", 1);
    for (int i = 0; i < 10; i++) tick();
    check("full_count", cap.size(), 128);
    check("full_done_once", done_cnt, 1);
    check("full_idle", busy, 1'b0);
    check("full_r0", get_word(0), 32'h0000_0000);
    check("full_r1", get_word(4), 32'h1122_3344);
    check("full_r2", get_word(8), 32'hCAFE_F00D);
    check("full_r31", get_word(124), 32'hDEAD_BEEF);
    errs = 0;
    for (int r = 0; r < 32; r++) begin
      w = rf[r];
      for (int b = 0; b < 4; b++)
        if (get_byte(4 * r + b) !== w[31 - 8 * b -: 8]) errs++;
    end
    check("full_all_bytes", errs, 0);

    // Abort after the sixth byte.
    cap.delete();
    done0 = done_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes("abort_wait", 6);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_done", done_cnt, done0);
    check("abort_no_bytes", cap.size(), 6);

    // Restart after abort begins at R0.
    cap.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes("restart_wait", 8);
    check("restart_r0", get_word(0), 32'h0000_0000);
    check("restart_r1", get_word(4), 32'h1122_3344);

    // Reset while in WAIT: outputs drop immediately.
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_wait");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_no_done", done_cnt, done0);
    cap.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes("rst_restart_wait", 8);
    check("rst_restart_r0", get_word(0), 32'h0000_0000);
    check("rst_restart_r1", get_word(4), 32'h1122_3344);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Spurious tx_done in IDLE, LOAD, SEND and coincident with tx_start.
    tx_done_spur = 1'b1;
    tick();
    tx_done_spur = 1'b0;
    tick();
    check("spur_idle_busy", busy, 1'b0);
    cap.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    tx_done_spur = 1'b1;
    tick();
    tick();
    check("spur_txs", tx_start, 1'b1);
    tx_done_spur = 1'b0;
    tick();
    tick();
    check("spur_no_advance", cap.size(), 1);
    check("spur_txs_low", tx_start, 1'b0);
    wait_bytes("spur_wait", 8);
    check("spur_r0", get_word(0), 32'h0000_0000);
    check("spur_r1", get_word(4), 32'h1122_3344);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
